if_stage_fq: RTL
================

Name: if_stage_fq

Overview:
Parametrised instruction-fetch stage for the next-generation pipelined LoongArch core. It replaces single-cycle direct-SRAM fetch with an SRAM-like req/addr_ok/data_ok interface and supports multiple outstanding requests. An in-order fetch queue decouples fetch from decode. Branch/jump redirects from later stages kill in-flight requests and already-queued instructions.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
FQ_DEPTH, 4, fetch-queue entries and max outstanding+queued (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
redirect_valid  in  1  redirect fetch this cycle
redirect_pc  in  ADDR_W  redirect target
inst_req  out  1  fetch request
inst_addr  out  ADDR_W  fetch address
inst_addr_ok  in  1  request accepted when inst_req&inst_addr_ok
inst_data_ok  in  1  one response returned, in request order
inst_rdata  in  DATA_W  response instruction
fs_valid  out  1  queue head valid
fs_pc  out  ADDR_W  PC of head
fs_inst  out  DATA_W  instruction of head
ds_allow_in  in  1  decode accepts head when fs_valid&ds_allow_in
fs_count  out  clog2(FQ_DEPTH)+1  queued entries

Behaviour:
- Async reset (resetn low, immediate, no clock needed): fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding O=0, discard D=0, queue empty. Outputs: inst_req=0, fs_valid=0, fs_count=0, inst_addr=RESET_PC, fs_pc/fs_inst=0.
- inst_addr=fetch_pc. inst_req = resetn & ~redirect_valid & (O+fs_count < FQ_DEPTH); credit is conservative (O includes to-be-discarded).
- Request handshake: fetch_pc += 4 (wraps mod 2^ADDR_W), O += 1. While inst_req=1 and addr_ok=0, inst_addr is held stable.
- data_ok: O -= 1. If D>0: drop response, D -= 1, resp_pc unchanged. Else: push {resp_pc, inst_rdata} to queue tail, resp_pc += 4.
- Same-cycle handshake and data_ok: O unchanged.
- Queue pop: fs_valid&ds_allow_in; head advances at the next edge. Push and pop can happen in the same cycle. Push never hits a full queue because of the credit rule.
- fs_pc/fs_inst come combinationally from the head entry. When empty, their value is don't-care but stable.
- Redirect (priority over all else):
  - fetch_pc and resp_pc load redirect_pc.
  - Queue is cleared, including any same-cycle push or pop.
  - D <= O - inst_data_ok, using the pre-update O. A same-cycle response is discarded.
  - No handshake occurs in the redirect cycle because inst_req=0. The first new request is at redirect_pc on the following cycle.
  - Back-to-back redirects: the last one wins. D is recomputed each time.
- inst_data_ok with O=0 is a protocol error: it is ignored (no push), and the simulation assertion fires.
- Counters are sized for 0..FQ_DEPTH, with no overflow or underflow under a legal protocol.
- Latency: for a response on cycle N, fs_valid is high on cycle N+1. No bypass from data_ok to the fs_* outputs.
- Reset asserted mid-operation drops all state. The memory side is expected to be reset together with this block, so no stale responses follow.

Test Plan:
1. Release reset with addr_ok=1, data_ok 1 cycle after each accept, and ds_allow_in=1 -> inst_addr goes 0x1c000000, 0x1c000004, … one per cycle; fs_pc follows the same sequence with 2-cycle lag; fs_inst matches the memory model.
2. ds_allow_in=0, FQ_DEPTH=4 -> exactly 4 accepts, then inst_req=0 and fs_count=4. Raise ds_allow_in -> one pop per cycle and inst_req reasserts the cycle after the first pop.
3. addr_ok=0 for 3 cycles with inst_req=1 -> inst_addr stays 0x1c000000 throughout; one accept when addr_ok rises.
4. 2 requests outstanding and 1 queued; redirect_valid with redirect_pc=0x1c000100 -> inst_req=0 that cycle and fs_count=0 next. The next 2 responses are dropped. The following cycle issues inst_addr=0x1c000100. The first delivered fs_pc is 0x1c000100.
5. Redirect in the same cycle as data_ok with O=2 -> D=1. That response and one later response are dropped, and no stale PC ever appears on fs_pc.
6. resetn driven low between clock edges while O=3 and fs_count=1 -> fs_valid and inst_req go to 0 immediately. After release, the first inst_addr is 0x1c000000 and fs_count=0.

Source files
------------

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with multiple outstanding SRAM-like requests
// and an in-order fetch queue that is flushed on redirect.
module if_stage_fq #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           DATA_W   = 32,
    parameter int unsigned           FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0]     RESET_PC = ADDR_W'(32'h1c000000),
    localparam int unsigned          IW       = $clog2(FQ_DEPTH),
    localparam int unsigned          CW       = IW + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              fs_valid,
    output logic [ADDR_W-1:0] fs_pc,
    output logic [DATA_W-1:0] fs_inst,
    input  logic              ds_allow_in,
    output logic [CW-1:0]     fs_count
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     head_q, head_d;
    logic [IW-1:0]     tail_q, tail_d;
    logic [ADDR_W-1:0] pc_q   [FQ_DEPTH];
    logic [DATA_W-1:0] inst_q [FQ_DEPTH];

    logic [CW:0] credit;
    logic        hs, dok, push, pop;

    // Outstanding requests count against queue space so a push never overflows
    assign credit   = {1'b0, out_q} + {1'b0, cnt_q};
    assign inst_req = resetn & ~redirect_valid
                    & (credit < (CW+1)'(FQ_DEPTH));
    assign inst_addr = fetch_pc_q;

    assign hs   = inst_req & inst_addr_ok;
    assign dok  = inst_data_ok & (out_q != '0);
    assign push = dok & (disc_q == '0) & ~redirect_valid;
    assign pop  = fs_valid & ds_allow_in & ~redirect_valid;

    assign fs_valid = (cnt_q != '0);
    assign fs_count = cnt_q;
    assign fs_pc    = pc_q[head_q];
    assign fs_inst  = inst_q[head_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        disc_d     = disc_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            out_d      = out_q - CW'(dok);
            disc_d     = out_q - CW'(dok);
            cnt_d      = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (hs)
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            out_d = out_q + CW'(hs) - CW'(dok);
            if (dok && disc_q != '0)
                disc_d = disc_q - CW'(1);
            if (push) begin
                resp_pc_d = resp_pc_q + ADDR_W'(4);
                tail_d    = tail_q + IW'(1);
            end
            if (pop)
                head_d = head_q + IW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[tail_q]   <= resp_pc_q;
            inst_q[tail_q] <= inst_rdata;
        end
    end

    a_no_stray_data: assert property (
        @(posedge clk) disable iff (!resetn) inst_data_ok |-> (out_q != '0));

endmodule
